// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM: instruction fetch (I) and data (D).
// Each access takes three cycles: grant in IDLE, strobe the RAM in ACC, pulse odv in RESP.
// Round-robin on ties, starting with D after reset.
module mem_arbiter #(
  parameter int unsigned a_width = 8,
  parameter int unsigned d_width = 16
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic               i_req,
  input  logic [a_width-1:0] i_addr,
  output logic [d_width-1:0] i_data,
  output logic               i_odv,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [a_width-1:0] d_addr,
  input  logic [d_width-1:0] d_wdata,
  output logic [d_width-1:0] d_rdata,
  output logic               d_odv,
  output logic [a_width-1:0] mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [d_width-1:0] mem_wdata,
  input  logic [d_width-1:0] mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_gnt_d;
  logic               r_last_d;
  logic               r_we;
  logic [d_width-1:0] r_i_data;
  logic [d_width-1:0] r_d_rdata;
  logic               r_i_odv;
  logic               r_d_odv;
  logic [a_width-1:0] r_mem_addr;
  logic               r_mem_rd;
  logic               r_mem_wr;
  logic [d_width-1:0] r_mem_wdata;
  logic               r_busy;

  logic               w_any;
  logic               w_pick_d;
  logic               w_d_wr;

  // Grant decision: a lone request wins, a tie goes to the port not served last
  always_comb begin
    w_any    = i_req | d_req;
    w_pick_d = d_req & (~i_req | ~r_last_d);
    w_d_wr   = w_pick_d & d_we;
  end

  // Arbiter FSM; RAM strobes are loaded on entry to ACC so they are high exactly in ACC
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      r_state     <= IDLE;
      r_gnt_d     <= 1'b0;
      r_last_d    <= 1'b0;
      r_we        <= 1'b0;
      r_i_data    <= '0;
      r_d_rdata   <= '0;
      r_i_odv     <= 1'b0;
      r_d_odv     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_i_odv <= 1'b0;
      r_d_odv <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= ACC;
            r_busy      <= 1'b1;
            r_gnt_d     <= w_pick_d;
            r_last_d    <= w_pick_d;
            r_we        <= w_d_wr;
            r_mem_addr  <= w_pick_d ? d_addr : i_addr;
            r_mem_rd    <= ~w_d_wr;
            r_mem_wr    <= w_d_wr;
            r_mem_wdata <= w_d_wr ? d_wdata : '0;
          end
        end
        ACC: begin
          r_state     <= RESP;
          r_mem_addr  <= '0;
          r_mem_rd    <= 1'b0;
          r_mem_wr    <= 1'b0;
          r_mem_wdata <= '0;
          if (!r_we) begin
            if (r_gnt_d) r_d_rdata <= mem_rdata;
            else         r_i_data  <= mem_rdata;
          end
          if (r_gnt_d) r_d_odv <= 1'b1;
          else         r_i_odv <= 1'b1;
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping
  always_comb begin
    i_data    = r_i_data;
    i_odv     = r_i_odv;
    d_rdata   = r_d_rdata;
    d_odv     = r_d_odv;
    mem_addr  = r_mem_addr;
    mem_rd    = r_mem_rd;
    mem_wr    = r_mem_wr;
    mem_wdata = r_mem_wdata;
    busy      = r_busy;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, checked every
// cycle against a transaction-timeline model (grant at cycle c -> strobe c+1 -> odv c+2).
module tb_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          g_clk;
  logic          g_clr;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic          i_odv;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_odv;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_arbiter #(.a_width(AW), .d_width(DW)) dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_odv(i_odv),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_odv(d_odv),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Environment RAM (combinational read) and the model's own view of memory contents
  logic [DW-1:0] ram    [0:255];
  logic [DW-1:0] shadow [0:255];
  assign mem_rdata = ram[mem_addr];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model state: timeline of the transaction in flight and the expected held outputs
  int            acc_c  = -10;
  int            resp_c = -10;
  int            free_c = 0;
  bit            last_d = 1'b0;
  bit            g_d, g_wr;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, g_rdata;
  logic [DW-1:0] exp_i  = '0;
  logic [DW-1:0] exp_d  = '0;
  bit            last_iodv, last_dodv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Per-cycle model: check outputs for this cycle, then decide the next grant
  task automatic model_step();
    bit in_acc, in_resp;
    last_iodv = i_odv;
    last_dodv = d_odv;
    if (mem_wr === 1'b1) ram[mem_addr] = mem_wdata;
    if (g_clr) begin
      chk("rst_mem_rd",  32'(mem_rd), 32'd0);
      chk("rst_mem_wr",  32'(mem_wr), 32'd0);
      chk("rst_i_odv",   32'(i_odv),  32'd0);
      chk("rst_d_odv",   32'(d_odv),  32'd0);
      chk("rst_busy",    32'(busy),   32'd0);
      chk("rst_i_data",  32'(i_data), 32'd0);
      chk("rst_d_rdata", 32'(d_rdata), 32'd0);
      acc_c  = -10;
      resp_c = -10;
      free_c = 0;
      last_d = 1'b0;
      exp_i  = '0;
      exp_d  = '0;
      return;
    end
    in_acc  = (cyc == acc_c);
    in_resp = (cyc == resp_c);
    if (in_resp && !g_wr) begin
      if (g_d) exp_d = g_rdata;
      else     exp_i = g_rdata;
    end
    chk("mem_rd",    32'(mem_rd),    32'(in_acc && !g_wr));
    chk("mem_wr",    32'(mem_wr),    32'(in_acc && g_wr));
    chk("mem_addr",  32'(mem_addr),  in_acc ? 32'(g_addr) : 32'd0);
    chk("mem_wdata", 32'(mem_wdata), (in_acc && g_wr) ? 32'(g_wdata) : 32'd0);
    chk("i_odv",     32'(i_odv),     32'(in_resp && !g_d));
    chk("d_odv",     32'(d_odv),     32'(in_resp && g_d));
    chk("busy",      32'(busy),      32'(in_acc || in_resp));
    chk("i_data",    32'(i_data),    32'(exp_i));
    chk("d_rdata",   32'(d_rdata),   32'(exp_d));
    if (cyc >= free_c && (i_req || d_req)) begin
      if (i_req && d_req) g_d = !last_d;
      else                g_d = d_req;
      last_d  = g_d;
      g_wr    = g_d && d_we;
      g_addr  = g_d ? d_addr : i_addr;
      g_wdata = d_wdata;
      g_rdata = shadow[g_addr];
      if (g_wr) shadow[g_addr] = d_wdata;
      acc_c  = cyc + 1;
      resp_c = cyc + 2;
      free_c = cyc + 3;
    end
  endtask

  // One clock: model at the falling edge, return 1 time unit after the rising edge
  task automatic tick();
    @(negedge g_clk);
    model_step();
    @(posedge g_clk);
    cyc++;
    #1;
  endtask

  task automatic wait_odv(input bit is_d, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (is_d ? last_dodv : last_iodv) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic do_i(input logic [AW-1:0] a);
    i_req  = 1'b1;
    i_addr = a;
    wait_odv(1'b0, "i_odv_timeout");
    i_req  = 1'b0;
  endtask

  task automatic do_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    wait_odv(1'b1, "d_odv_timeout");
    d_req   = 1'b0;
  endtask

  initial begin
    int seq [3];
    int nseen;
    bit i_pend, d_pend;

    for (int a = 0; a < 256; a++) begin
      ram[a]    = 16'($urandom);
      shadow[a] = ram[a];
    end
    ram[5]  = 16'hABCD; shadow[5]  = 16'hABCD;
    ram[7]  = 16'h1357; shadow[7]  = 16'h1357;

    g_clr = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    g_clr = 1'b0;
    tick();

    // Lone fetch from 0x05
    do_i(8'h05);
    chk("fetch_data", 32'(i_data), 32'h0000ABCD);
    tick();

    // Data write leaves d_rdata alone; read back returns written value
    do_d(1'b1, 8'h10, 16'h0042);
    chk("wr_keeps_rdata", 32'(d_rdata), 32'd0);
    do_d(1'b0, 8'h10, 16'h0000);
    chk("rd_after_wr", 32'(d_rdata), 32'h00000042);
    tick();

    // Reset asserted while the fetch strobe is up
    i_req  = 1'b1;
    i_addr = 8'h03;
    tick();
    chk("pre_rst_mem_rd", 32'(mem_rd), 32'd1);
    g_clr = 1'b1;
    i_req = 1'b0;
    #1;
    chk("rst_acc_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_acc_busy",   32'(busy),   32'd0);
    chk("rst_acc_i_data", 32'(i_data), 32'd0);
    tick();
    g_clr = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Tie held on both ports after reset: D, I, D
    i_req = 1'b1; i_addr = 8'h05;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; d_wdata = '0;
    nseen = 0;
    for (int k = 0; k < 20 && nseen < 3; k++) begin
      tick();
      if (last_dodv) begin seq[nseen] = 1; nseen++; end
      else if (last_iodv) begin seq[nseen] = 0; nseen++; end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("tie_count", 32'(nseen), 32'd3);
    chk("tie_first_d",  32'(seq[0]), 32'd1);
    chk("tie_second_i", 32'(seq[1]), 32'd0);
    chk("tie_third_d",  32'(seq[2]), 32'd1);
    tick();

    // Fetch request dropped during ACC still completes
    i_req  = 1'b1;
    i_addr = 8'h07;
    tick();
    i_req  = 1'b0;
    wait_odv(1'b0, "early_drop_odv");
    chk("early_drop_data", 32'(i_data), 32'h00001357);
    for (int k = 0; k < 3; k++) tick();

    // Random traffic on both ports
    i_pend = 1'b0;
    d_pend = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      tick();
      if (last_iodv) begin i_pend = 1'b0; i_req = 1'b0; end
      if (last_dodv) begin d_pend = 1'b0; d_req = 1'b0; end
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1;
        i_req  = 1'b1;
        i_addr = 8'($urandom_range(0, 15));
      end else if (i_pend && i_req && acc_c == cyc && !g_d && $urandom_range(0, 3) == 0) begin
        i_req = 1'b0;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend  = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 8'($urandom_range(0, 15));
        d_wdata = 16'($urandom);
      end else if (d_pend && d_req && acc_c == cyc && g_d && $urandom_range(0, 3) == 0) begin
        d_req = 1'b0;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
